// File: rtl/bp_pkg.sv
// Shared encodings and PC slicing helpers for the BTB + bimodal branch predictor.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  localparam logic [1:0] CTR_RST = CTR_WNT;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Callers zero-extend the PC to 64 bits and cast the result down to IDX_W / TAG_W.
  function automatic logic [63:0] bp_index(input logic [63:0] pc, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter next-state; purely combinational, no handshake.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// BTB + 2-bit bimodal predictor: 0-cycle lookup and mispredict, table writes visible next cycle.
// No backpressure: one lookup and one EX resolution accepted every cycle.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = ADDR_W - $clog2(ENTRIES) - 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  output logic              ready_o,
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              ex_is_branch_i,
  input  logic              ex_taken_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  input  logic              ex_pred_taken_i,
  input  logic [ADDR_W-1:0] ex_pred_target_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  br_count_o,
  output logic [CNT_W-1:0]  mp_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] tgt;
    logic [1:0]        ctr;
  } entry_t;

  entry_t             tbl_q [ENTRIES];
  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic [CNT_W-1:0]   br_q, br_d, mp_q, mp_d;

  logic [IDX_W-1:0]   if_idx, ex_idx, wr_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  entry_t             if_ent, ex_ent, wr_ent;
  logic               if_hit, ex_hit, wr_en;
  logic               res, alias_q;
  logic [1:0]         ctr_nxt;

  assign if_idx = IDX_W'(bp_index(64'(if_pc_i), IDX_W));
  assign if_tag = TAG_W'(bp_tag(64'(if_pc_i), IDX_W));
  assign ex_idx = IDX_W'(bp_index(64'(ex_pc_i), IDX_W));
  assign ex_tag = TAG_W'(bp_tag(64'(ex_pc_i), IDX_W));

  assign if_ent = tbl_q[if_idx];
  assign ex_ent = tbl_q[ex_idx];
  assign if_hit = if_ent.vld && (if_ent.tag == if_tag);
  assign ex_hit = ex_ent.vld && (ex_ent.tag == ex_tag);

  assign ready_o       = (state_q == ST_RUN);
  assign pred_taken_o  = ready_o && if_hit && if_ent.ctr[1];
  assign pred_target_o = pred_taken_o ? if_ent.tgt : '0;

  assign res     = ex_valid_i && ex_is_branch_i;
  assign alias_q = ex_valid_i && !ex_is_branch_i && ex_pred_taken_i;

  assign mispredict_o = (res && ((ex_taken_i != ex_pred_taken_i) ||
                                 (ex_taken_i && (ex_target_i != ex_pred_target_i)))) || alias_q;
  assign redirect_pc_o = (res && ex_taken_i) ? ex_target_i : ex_pc_i + ADDR_W'(4);

  bp_sat_counter u_sat_ctr (
    .ctr_i (ex_ent.ctr),
    .inc_i (ex_taken_i),
    .ctr_o (ctr_nxt)
  );

  // Single write port shared by the init sweep and EX updates; INIT owns it exclusively.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = ex_idx;
    wr_ent = ex_ent;
    if (reset_i) begin
      wr_en = 1'b0;
    end else if (state_q == ST_INIT) begin
      wr_en      = 1'b1;
      wr_idx     = sweep_q;
      wr_ent     = '0;
      wr_ent.ctr = CTR_RST;
    end else if (res) begin
      if (ex_hit) begin
        wr_en      = 1'b1;
        wr_ent.ctr = ctr_nxt;
        if (ex_taken_i) wr_ent.tgt = ex_target_i;
      end else if (ex_taken_i) begin
        wr_en      = 1'b1;
        wr_ent.vld = 1'b1;
        wr_ent.tag = ex_tag;
        wr_ent.tgt = ex_target_i;
        wr_ent.ctr = CTR_WT;
      end
    end else if (alias_q && ex_hit) begin
      wr_en      = 1'b1;
      wr_ent.vld = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) tbl_q[wr_idx] <= wr_ent;
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == IDX_W'(ENTRIES - 1)) state_d = ST_RUN;
    end
    br_d = br_q + CNT_W'(res);
    mp_d = mp_q + CNT_W'(mispredict_o);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      br_q    <= '0;
      mp_q    <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      br_q    <= br_d;
      mp_q    <= mp_d;
    end
  end

  assign br_count_o = br_q;
  assign mp_count_o = mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;

  localparam int AW = 32;
  localparam int NE = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] if_pc;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          ready;
  logic          ex_valid;
  logic [AW-1:0] ex_pc;
  logic          ex_is_branch;
  logic          ex_taken;
  logic [AW-1:0] ex_target;
  logic          ex_pred_taken;
  logic [AW-1:0] ex_pred_target;
  logic          mispredict;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] br_count;
  logic [CW-1:0] mp_count;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_W(AW), .ENTRIES(NE), .CNT_W(CW)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .if_pc_i          (if_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .ready_o          (ready),
    .ex_valid_i       (ex_valid),
    .ex_pc_i          (ex_pc),
    .ex_is_branch_i   (ex_is_branch),
    .ex_taken_i       (ex_taken),
    .ex_target_i      (ex_target),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .mispredict_o     (mispredict),
    .redirect_pc_o    (redirect_pc),
    .br_count_o       (br_count),
    .mp_count_o       (mp_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: table as plain arrays, counter as an integer 0..3.
  bit            m_vld [NE];
  logic [31:0]   m_tag [NE];
  logic [31:0]   m_tgt [NE];
  int            m_ctr [NE];
  int            m_init  = 0;
  bit            m_known = 0;
  logic [31:0]   m_br = '0;
  logic [31:0]   m_mp = '0;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(NE));
  endfunction

  function automatic bit m_ready();
    return m_init >= NE;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_vld[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 8));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_ready() && m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_ptaken(pc) ? m_tgt[m_idx(pc)] : 32'h0;
  endfunction

  task automatic tick();
    bit          res, al, mp_e, hit, rst;
    int          ix;
    logic [31:0] rd;
    #1;
    res  = ex_valid && ex_is_branch;
    al   = ex_valid && !ex_is_branch && ex_pred_taken;
    mp_e = (res && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target))) || al;
    rd   = (res && ex_taken) ? ex_target : ex_pc + 32'd4;
    chk("mispredict", mispredict, mp_e);
    chk("redirect_pc", redirect_pc, rd);
    if (m_known) begin
      chk("ready", ready, m_ready());
      chk("pred_taken", pred_taken, m_ptaken(if_pc));
      chk("pred_target", pred_target, m_ptgt(if_pc));
      chk("br_count", br_count, m_br);
      chk("mp_count", mp_count, m_mp);
    end
    ix  = m_idx(ex_pc);
    hit = m_hit(ex_pc);
    rst = reset;
    @(posedge clk);
    if (rst) begin
      m_init  = 0;
      m_br    = '0;
      m_mp    = '0;
      m_known = 1;
    end else begin
      m_br = m_br + 32'(res);
      m_mp = m_mp + 32'(mp_e);
      if (!m_ready()) begin
        if (m_known) begin
          m_vld[m_init] = 0;
          m_ctr[m_init] = 1;
          m_init++;
        end
      end else if (res) begin
        if (hit) begin
          m_ctr[ix] = ex_taken ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                               : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
          if (ex_taken) m_tgt[ix] = ex_target;
        end else if (ex_taken) begin
          m_vld[ix] = 1;
          m_tag[ix] = ex_pc >> 8;
          m_tgt[ix] = ex_target;
          m_ctr[ix] = 2;
        end
      end else if (al && hit) begin
        m_vld[ix] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_ex(input bit v, input logic [31:0] pc, input bit br, input bit tk,
                        input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
    ex_valid       = v;
    ex_pc          = pc;
    ex_is_branch   = br;
    ex_taken       = tk;
    ex_target      = tg;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
  endtask

  initial begin
    reset = 1'b1;
    if_pc = '0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset and full init sweep
    tick();
    reset = 1'b0;
    for (int i = 0; i < NE; i++) begin
      if (i == 0 || i == NE - 1) begin
        #1 chk("ready_during_init", ready, 1'b0);
      end
      tick();
    end
    #1 chk("ready_after_sweep", ready, 1'b1);
    if_pc = 32'h40;
    #1 chk("pred_after_init", pred_taken, 1'b0);

    // Taken branch allocates
    set_ex(1, 32'h40, 1, 1, 32'h100, 0, 32'h0);
    #1 chk("alloc_misp", mispredict, 1'b1);
    chk("alloc_redirect", redirect_pc, 32'h100);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1 chk("alloc_mp_count", mp_count, 32'd1);
    chk("alloc_pred", pred_taken, 1'b1);
    chk("alloc_target", pred_target, 32'h100);

    // Two not-taken resolutions carrying the prediction: 10 -> 01 -> 00
    set_ex(1, 32'h40, 1, 0, 32'h0, 1, 32'h100);
    #1 chk("nt1_misp", mispredict, 1'b1);
    chk("nt1_redirect", redirect_pc, 32'h44);
    tick();
    set_ex(1, 32'h40, 1, 0, 32'h0, 0, 32'h0);
    #1 chk("nt2_misp", mispredict, 1'b0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1 chk("nt_pred", pred_taken, 1'b0);
    chk("nt_br_count", br_count, 32'd3);

    // Bring ctr back to 10, then a taken resolution with a new target
    set_ex(1, 32'h40, 1, 1, 32'h100, 0, 32'h0);
    tick();
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1 chk("wt_pred", pred_taken, 1'b1);
    set_ex(1, 32'h40, 1, 1, 32'h200, 1, 32'h100);
    #1 chk("tgt_misp", mispredict, 1'b1);
    chk("tgt_redirect", redirect_pc, 32'h200);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1 chk("tgt_new", pred_target, 32'h200);
    // One not-taken step from 11 must still predict taken
    set_ex(1, 32'h40, 1, 0, 32'h0, 1, 32'h200);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1 chk("st_pred", pred_taken, 1'b1);

    // Alias invalidation
    set_ex(1, 32'h40, 0, 0, 32'h0, 1, 32'h200);
    #1 chk("alias_misp", mispredict, 1'b1);
    chk("alias_redirect", redirect_pc, 32'h44);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1 chk("alias_pred", pred_taken, 1'b0);

    // Reset mid-sweep at index 30, counters still counting during INIT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_ex(1, 32'h80, 1, 1, 32'h300, 0, 32'h0);
    for (int i = 0; i < 30; i++) tick();
    #1 chk("init_br_count", br_count, 32'd30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_br_count", br_count, 32'd0);
    chk("rst_mp_count", mp_count, 32'd0);
    for (int i = 0; i < NE; i++) begin
      if (i == NE - 1) begin
        #1 chk("ready_restart", ready, 1'b0);
      end
      tick();
    end
    if_pc = 32'h80;
    #1 chk("ready_restart_done", ready, 1'b1);
    chk("init_update_dropped", pred_taken, 1'b0);

    // Randomized traffic over a small PC pool to force hits, conflicts and aliases
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc, tg;
      bit          carry;
      reset = ($urandom_range(0, 799) == 0);
      if_pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
      pc    = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
      tg    = 32'h1000 + (32'($urandom_range(0, 15)) << 4);
      carry = ($urandom_range(0, 3) != 0);
      set_ex($urandom_range(0, 3) != 0, pc, $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1, tg,
             carry ? m_ptaken(pc) : 1'($urandom_range(0, 1)),
             carry ? m_ptgt(pc) : tg);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
